fp_sub_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing out = src1 − src2. It is the subtract counterpart of the combinational adder in the floating-point ALU and is shared by the ALU's SUB and CMP paths. The block trades latency for area: it uses one right shifter for alignment and one left shifter for normalization, each moving one bit per cycle, and a start/busy/done handshake.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_unpack.sv | 27 ++
 rtl/fp_sub_seq.sv | 193 +++++++++++++++++++
 tb/tb_fp_sub_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the floating-point ALU: field widths,
// canned special results and the unpacked-operand record.
package fp_pkg;

   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W:0]   mant;
   } fp_unp_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational binary32 field extraction: hidden-bit insertion, effective
// exponent for denormals and NaN/Inf classification.
module fp_unpack
   import fp_pkg::*;
(
   input  logic [31:0] x,
   output fp_unp_t     u,
   output logic        is_nan,
   output logic        is_inf
);

   logic [EXP_W-1:0]  e;
   logic [FRAC_W-1:0] f;

   assign e = x[30:23];
   assign f = x[22:0];

   always_comb begin
      u.sign = x[31];
      // denormals sit at the same scale as exponent 1
      u.exp  = (e == '0) ? EXP_W'(1) : e;
      u.mant = {e != '0, f};
      is_inf = (e == '1) && (f == '0);
      is_nan = (e == '1) && (f != '0);
   end

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle binary32 subtractor out = src1 - src2, one-bit-per-cycle align
// and normalize shifters. Define FP_SUB_ROUND_EN for round-to-nearest-even.
//
// state  | meaning
// IDLE   | waiting for start
// UNPACK | classify operands, order by magnitude, load align count
// ALIGN  | shift smaller mantissa right one bit per cycle, sticky collect
// ADDSUB | add or subtract mantissas
// NORM   | one normalization step per cycle
// ROUND  | round (or truncate) and pack into out
// DONE   | out valid for one cycle, new start accepted
module fp_sub_seq
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   output logic [31:0] out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, DONE
   } state_t;

   state_t state, state_nx;

   logic [31:0] op1, op2;
   logic [27:0] ma, mb;
   logic [9:0]  ea;
   logic        sa, sb;
   logic        zero_res;
   logic [4:0]  cnt;

   fp_unp_t u1, u2, ua, ub;
   logic    nan1, nan2, inf1, inf2;

   fp_unpack u_unp1 (.x(op1), .u(u1), .is_nan(nan1), .is_inf(inf1));
   fp_unpack u_unp2 (.x(op2), .u(u2), .is_nan(nan2), .is_inf(inf2));

   logic        swap, special;
   logic [31:0] special_val;
   logic [7:0]  ediff;
   logic [4:0]  k;

   always_comb begin
      swap    = {u2.exp, u2.mant} > {u1.exp, u1.mant};
      ua      = swap ? u2 : u1;
      ub      = swap ? u1 : u2;
      ediff   = ua.exp - ub.exp;
      k       = (ediff > 8'd27) ? 5'd27 : ediff[4:0];
      special = nan1 | nan2 | inf1 | inf2;
      special_val = QNAN;
      if (nan1 | nan2)
         special_val = QNAN;
      else if (inf1 & inf2)
         special_val = (u1.sign != u2.sign) ? QNAN : {u1.sign, POS_INF[30:0]};
      else if (inf1)
         special_val = {u1.sign, POS_INF[30:0]};
      else if (inf2)
         special_val = {u2.sign, POS_INF[30:0]};
   end

   function automatic logic need_norm(input logic [27:0] m, input logic [9:0] e);
      return m[27] || (!m[26] && (e > 10'd1));
   endfunction

   logic [27:0] sum, norm_m;
   logic [9:0]  norm_e;

   always_comb begin
      sum = (sa == sb) ? (ma + mb) : (ma - mb);
      if (ma[27]) begin
         norm_m = {1'b0, ma[27:2], ma[1] | ma[0]};
         norm_e = ea + 10'd1;
      end else begin
         norm_m = {ma[26:0], 1'b0};
         norm_e = ea - 10'd1;
      end
   end

   logic        up;
   logic [24:0] rnd;
   logic [23:0] m_rnd;
   logic [9:0]  e_rnd;
   logic [31:0] pack_val;

   always_comb begin
`ifdef FP_SUB_ROUND_EN
      up = ma[2] & (ma[1] | ma[0] | ma[3]);
`else
      up = 1'b0;
`endif
      rnd = {1'b0, ma[26:3]} + {24'd0, up};
      if (rnd[24]) begin
         m_rnd = rnd[24:1];
         e_rnd = ea + 10'd1;
      end else begin
         m_rnd = rnd[23:0];
         e_rnd = ea;
      end
      // hidden bit still clear after normalization means a denormal result
      if (zero_res)
         pack_val = 32'd0;
      else if (e_rnd >= 10'(EXP_MAX))
         pack_val = {sa, POS_INF[30:0]};
      else if (!m_rnd[23])
         pack_val = {sa, 8'd0, m_rnd[22:0]};
      else
         pack_val = {sa, e_rnd[7:0], m_rnd[22:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = start ? UNPACK : IDLE;
         UNPACK: begin
            if (special)      state_nx = DONE;
            else if (k == '0) state_nx = ADDSUB;
            else              state_nx = ALIGN;
         end
         ALIGN:  state_nx = (cnt == 5'd1) ? ADDSUB : ALIGN;
         ADDSUB: begin
            if (sum == '0)              state_nx = ROUND;
            else if (need_norm(sum, ea)) state_nx = NORM;
            else                        state_nx = ROUND;
         end
         NORM:   state_nx = need_norm(norm_m, norm_e) ? NORM : ROUND;
         ROUND:  state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op1      <= '0;
         op2      <= '0;
         ma       <= '0;
         mb       <= '0;
         ea       <= '0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         zero_res <= 1'b0;
         cnt      <= '0;
         out      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  op1 <= src1;
                  op2 <= {~src2[31], src2[30:0]};
               end
            end
            UNPACK: begin
               sa       <= ua.sign;
               sb       <= ub.sign;
               ea       <= {2'b00, ua.exp};
               ma       <= {1'b0, ua.mant, 3'b000};
               mb       <= {1'b0, ub.mant, 3'b000};
               cnt      <= k;
               zero_res <= 1'b0;
               if (special) out <= special_val;
            end
            ALIGN: begin
               mb  <= {1'b0, mb[27:2], mb[1] | mb[0]};
               cnt <= cnt - 5'd1;
            end
            ADDSUB: begin
               ma       <= sum;
               zero_res <= (sum == '0);
            end
            NORM: begin
               ma <= norm_m;
               ea <= norm_e;
            end
            ROUND: out <= pack_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Scoreboard bench for fp_sub_seq: expected results come from an exact
// wide-integer model of binary32 subtraction.
module tb_fp_sub_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic [31:0] out;
   logic        busy, done;

   fp_sub_seq dut (
      .clk(clk), .rst(rst), .start(start), .src1(src1), .src2(src2),
      .out(out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] val;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] last_out = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // exact value scaled by 2^149, then rounded to binary32
   function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
      logic         sx, sy, rs, nx, ny, ix, iy;
      int           ex, ey, p, s, e;
      logic [23:0]  mx, my;
      logic [299:0] vx, vy, mag, q, rem, half;
      logic [24:0]  m;
      sx = x[31];
      sy = ~y[31];
      nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      if (nx || ny) return 32'h7FC00000;
      if (ix && iy) return (sx != sy) ? 32'h7FC00000 : {sx, 31'h7F800000};
      if (ix) return {sx, 31'h7F800000};
      if (iy) return {sy, 31'h7F800000};
      ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
      ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
      mx = {x[30:23] != 0, x[22:0]};
      my = {y[30:23] != 0, y[22:0]};
      vx = 300'(mx) << (ex - 1);
      vy = 300'(my) << (ey - 1);
      if (sx == sy)      begin mag = vx + vy; rs = sx; end
      else if (vx >= vy) begin mag = vx - vy; rs = sx; end
      else               begin mag = vy - vx; rs = sy; end
      if (mag == 0) return 32'h0;
      p = 299;
      while (!mag[p]) p--;
      if (p < 23) return {rs, 8'd0, mag[22:0]};
      s = p - 23;
      q = mag >> s;
      m = {1'b0, q[23:0]};
      e = p - 22;
`ifdef FP_SUB_ROUND_EN
      if (s > 0) begin
         rem  = mag & ((300'd1 << s) - 300'd1);
         half = 300'd1 << (s - 1);
         if (rem > half || (rem == half && m[0])) m = m + 25'd1;
         if (m[24]) begin m = m >> 1; e++; end
      end
`else
      rem  = '0;
      half = '0;
`endif
      if (e >= 255) return {rs, 31'h7F800000};
      return {rs, 8'(e), m[22:0]};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst) last_out = '0;
      else if (done) begin
         if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            e = sbq.pop_front();
            chk("result", out, e.val);
            if (e.lat > 0) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
         end
         last_out = out;
      end else
         chk("hold", out, last_out);
   end

   // call at posedge+1 with the DUT in IDLE or DONE
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input int lat);
      exp_t e;
      src1 = a;
      src2 = b;
      start = 1'b1;
      e.val = ref_sub(a, b);
      e.lat = lat;
      e.acc = cyc + 1;
      sbq.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done;
      for (int i = 0; i < 80; i++) begin
         if (done) break;
         @(posedge clk); #1;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input int lat);
      issue(a, b, lat);
      wait_done();
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rnd_op(input logic [31:0] other, input int mode);
      logic [31:0] r;
      int          e;
      r = $urandom;
      case (mode)
         1: begin
            e = int'(other[30:23]) + int'($urandom_range(0, 4)) - 2;
            if (e < 0) e = 0;
            if (e > 254) e = 254;
            r[30:23] = 8'(e);
         end
         2: r[30:23] = 8'($urandom_range(0, 2));
         3: case ($urandom_range(0, 5))
               0: r = 32'h7F800000;
               1: r = 32'hFF800000;
               2: r = 32'h7FA00000;
               3: r = 32'h00000000;
               4: r = 32'h80000000;
               default: r = 32'h7F7FFFFF;
            endcase
         4: r = {r[31], other[30:0]};
         5: r = {r[31], other[30:4], r[3:0]};
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      logic [31:0] a, b;
      rst = 1'b1;
      #2;
      chk("reset_out", out, 32'h0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      run(32'h40400000, 32'h3F800000, 5);
      run(32'h3F800000, 32'hBF800000, 5);
      run(32'h3F800000, 32'h3F800000, 4);
      run(32'h7F800000, 32'h7F800000, 2);
      run(32'h3F800000, 32'hB3C00000, 28);
      run(32'h7F7FFFFF, 32'hFF7FFFFF, 5);
      run(32'h7FC00000, 32'h3F800000, 2);
      run(32'h3F800000, 32'h7F800000, 2);
      run(32'h00000003, 32'h00000001, 4);

      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a[30:23] = 8'($urandom_range(0, 2));
         b = rnd_op(a, int'($urandom_range(0, 5)));
         if ($urandom_range(0, 1) == 1) run(a, b, 0);
         else run(b, a, 0);
      end

      // reset in the middle of ALIGN
      run(32'h40400000, 32'h3F800000, 5);
      issue(32'h3F800000, 32'hB3C00000, 28);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      sbq.delete();
      #1;
      chk("midreset_out", out, 32'h0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      run(32'h40400000, 32'h3F800000, 5);

      // start pulsed while busy must be ignored
      issue(32'h40400000, 32'h3F800000, 5);
      @(posedge clk); #1;
      src1 = 32'h3F800000;
      src2 = 32'h3F800000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      @(posedge clk); #1;

      // back-to-back: start during the DONE cycle
      issue(32'h3F800000, 32'hBF800000, 5);
      wait_done();
      issue(32'h40400000, 32'h3F800000, 5);
      wait_done();

      repeat (4) @(posedge clk);
      #1;
      chk("queue_empty", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
